grf_write_arbiter: RTL and testbench

//  Shares the single GRF write port (we/a3/wd) between the W-stage writeback and a

---
 rtl/grfarb_pkg.sv | 30 +++
 rtl/grfarb_fifo.sv | 77 +++++++
 rtl/grf_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_grf_write_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grfarb_pkg.sv
// Shared types and constants for the GRF write-port arbiter.
// The optional starvation guard is enabled with the GRFARB_STARVE_GUARD_EN macro.
package grfarb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 1 << REG_ADDR_W;

   // One pending register-file write: destination plus data.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] a3;
      logic [DATA_W-1:0]     wd;
   } wr_req_t;

   // Which source owns the GRF write port in the current cycle.
   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_WB   = 2'd1,
      GRANT_AUX  = 2'd2
   } grant_e;

   // One-hot decode of a register number, used to build the busy mask.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
      logic [NUM_REGS-1:0] v;
      v    = '0;
      v[a] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/grfarb_fifo.sv
// Circular queue for deferred auxiliary GRF writes.
// Keeps a valid bit per slot so the top can see every pending destination,
// not just the head. Push is ignored when full, pop is ignored when empty.
module grfarb_fifo
   import grfarb_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                                clk,
   input  logic                                clr,
   input  logic                                push_i,
   input  wr_req_t                             push_req_i,
   input  logic                                pop_i,
   output wr_req_t                             head_o,
   output logic                                full_o,
   output logic                                empty_o,
   output logic [CNT_W-1:0]                    count_o,
   output logic [DEPTH-1:0]                    entry_valid_o,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0]    entry_a3_o
);

   wr_req_t           mem_q [DEPTH];
   logic [DEPTH-1:0]  valid_q;
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              do_push;
   logic              do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Pointers, occupancy and slot valid bits; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
      end else begin
         if (do_push) begin
            valid_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q          <= wr_ptr_q + 1'b1;
         end
         // When both fire the slots differ (0 < count < DEPTH), so no clash.
         if (do_pop) begin
            valid_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q          <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Payload storage; contents are qualified by valid_q so no reset is needed.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_req_i;
      end
   end

   assign head_o        = mem_q[rd_ptr_q];
   assign count_o       = count_q;
   assign entry_valid_o = valid_q;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign entry_a3_o[gi] = mem_q[gi].a3;
   end

endmodule

// File: rtl/grf_write_arbiter.sv
// Shares the single GRF write port between W-stage writeback and a queued
// long-latency auxiliary producer. WB wins with zero latency; aux writes drain
// in FIFO order into cycles WB leaves idle. Define GRFARB_STARVE_GUARD_EN to
// add a starvation guard that periodically freezes WB for one cycle.
module grf_write_arbiter
   import grfarb_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                      clk,
   input  logic                      clr,
   input  logic                      wb_we,
   input  logic [REG_ADDR_W-1:0]     wb_a3,
   input  logic [DATA_W-1:0]         wb_wd,
   input  logic                      aux_valid,
   output logic                      aux_ready,
   input  logic [REG_ADDR_W-1:0]     aux_a3,
   input  logic [DATA_W-1:0]         aux_wd,
   output logic                      grf_we,
   output logic [REG_ADDR_W-1:0]     grf_a3,
   output logic [DATA_W-1:0]         grf_wd,
   output logic [NUM_REGS-1:0]       busy_mask,
   output logic [$clog2(DEPTH):0]    aux_count,
   output logic                      wb_hold
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
      $error("grf_write_arbiter: DEPTH must be a power of 2 >= 2 and STARVE_LIMIT >= 1");
   end

   wr_req_t                          push_req;
   wr_req_t                          head;
   logic                             push;
   logic                             pop;
   logic                             full;
   logic                             empty;
   logic [DEPTH-1:0]                 entry_valid;
   logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_a3;
   logic [NUM_REGS-1:0]              entry_mask [DEPTH];
   logic                             wb_req;
   grant_e                           grant;

   // Writes to $0 are architecturally void, so they never claim the port or a slot.
   assign wb_req    = wb_we && (wb_a3 != '0);
   assign aux_ready = !full;
   assign push      = aux_valid && !full && (aux_a3 != '0);
   assign push_req  = '{a3: aux_a3, wd: aux_wd};
   assign pop       = (grant == GRANT_AUX);

   grfarb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk           (clk),
      .clr           (clr),
      .push_i        (push),
      .push_req_i    (push_req),
      .pop_i         (pop),
      .head_o        (head),
      .full_o        (full),
      .empty_o       (empty),
      .count_o       (aux_count),
      .entry_valid_o (entry_valid),
      .entry_a3_o    (entry_a3)
   );

   // Port owner: a guard-forced hold beats WB, WB beats the queue, nothing during reset.
   always_comb begin
      grant = GRANT_NONE;
      if (clr) begin
         grant = GRANT_NONE;
      end else if (wb_hold && !empty) begin
         grant = GRANT_AUX;
      end else if (wb_req) begin
         grant = GRANT_WB;
      end else if (!empty) begin
         grant = GRANT_AUX;
      end
   end

   // Drive the GRF write port from the granted source; idle port is all zeros.
   always_comb begin
      grf_we = 1'b0;
      grf_a3 = '0;
      grf_wd = '0;
      case (grant)
         GRANT_WB: begin
            grf_we = 1'b1;
            grf_a3 = wb_a3;
            grf_wd = wb_wd;
         end
         GRANT_AUX: begin
            grf_we = 1'b1;
            grf_a3 = head.a3;
            grf_wd = head.wd;
         end
         default: begin
            grf_we = 1'b0;
         end
      endcase
   end

   // Busy mask is built only from registered slot state, never from this cycle's inputs.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
      assign entry_mask[gi] = entry_valid[gi] ? reg_onehot(entry_a3[gi]) : '0;
   end

   // OR-reduce the per-slot one-hot masks; duplicates stay set until the last one pops.
   always_comb begin
      busy_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         busy_mask = busy_mask | entry_mask[i];
      end
   end

`ifdef GRFARB_STARVE_GUARD_EN
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   logic [STARVE_W-1:0] starve_q;
   logic [STARVE_W-1:0] starve_d;
   logic [STARVE_W-1:0] starve_inc;
   logic                hold_q;
   logic                hold_d;

   assign starve_inc = starve_q + 1'b1;

   // Count cycles the queue waits behind WB; any pop restarts the count.
   always_comb begin
      starve_d = starve_q;
      hold_d   = 1'b0;
      if (pop) begin
         starve_d = '0;
      end else if (grant == GRANT_WB && !empty) begin
         starve_d = starve_inc;
         hold_d   = (starve_inc == STARVE_W'(STARVE_LIMIT));
      end
   end

   // The hold pulse lasts one cycle: the head pops during it, which clears the count.
   always_ff @(posedge clk) begin
      if (clr) begin
         starve_q <= '0;
         hold_q   <= 1'b0;
      end else begin
         starve_q <= starve_d;
         hold_q   <= hold_d;
      end
   end

   assign wb_hold = hold_q;
`else
   assign wb_hold = 1'b0;
`endif

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Randomized and directed bench for grf_write_arbiter with a queue-based
// reference model. Build with GRFARB_STARVE_GUARD_EN to exercise the guard.
module tb_grf_write_arbiter;

   localparam int DEPTH        = 4;
   localparam int STARVE_LIMIT = 8;
`ifdef GRFARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        clr;
   logic        wb_we;
   logic [4:0]  wb_a3;
   logic [31:0] wb_wd;
   logic        aux_valid;
   logic        aux_ready;
   logic [4:0]  aux_a3;
   logic [31:0] aux_wd;
   logic        grf_we;
   logic [4:0]  grf_a3;
   logic [31:0] grf_wd;
   logic [31:0] busy_mask;
   logic [2:0]  aux_count;
   logic        wb_hold;

   always #5 clk = ~clk;

   grf_write_arbiter #(
      .DEPTH        (DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk       (clk),
      .clr       (clr),
      .wb_we     (wb_we),
      .wb_a3     (wb_a3),
      .wb_wd     (wb_wd),
      .aux_valid (aux_valid),
      .aux_ready (aux_ready),
      .aux_a3    (aux_a3),
      .aux_wd    (aux_wd),
      .grf_we    (grf_we),
      .grf_a3    (grf_a3),
      .grf_wd    (grf_wd),
      .busy_mask (busy_mask),
      .aux_count (aux_count),
      .wb_hold   (wb_hold)
   );

   // Reference model: pending aux writes in arrival order, plus guard bookkeeping.
   typedef struct {
      logic [4:0]  a3;
      logic [31:0] wd;
   } req_t;

   req_t q[$];
   int   blocked_cycles = 0;
   bit   hold_m         = 1'b0;
   bit   chk_regs       = 1'b0;
   int   n_cmp          = 0;
   int   n_bad          = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_busy();
      logic [31:0] m;
      m = '0;
      foreach (q[i]) m[q[i].a3] = 1'b1;
      return m;
   endfunction

   task automatic drive(input logic c, input logic we, input logic [4:0] a3,
                        input logic [31:0] wd, input logic av, input logic [4:0] aa3,
                        input logic [31:0] awd);
      clr       = c;
      wb_we     = we;
      wb_a3     = a3;
      wb_wd     = wd;
      aux_valid = av;
      aux_a3    = aa3;
      aux_wd    = awd;
   endtask

   // One clock: compare outputs at the falling edge, then advance the model over the rising edge.
   task automatic step();
      bit          wb_req;
      bit          take_head;
      bit          e_we;
      logic [4:0]  e_a3;
      logic [31:0] e_wd;
      bit          full_m;
      bit          nonempty_m;
      bit          new_hold;
      req_t        r;
      @(negedge clk);
      wb_req    = wb_we && (wb_a3 != 5'd0);
      take_head = 1'b0;
      e_we      = 1'b0;
      e_a3      = '0;
      e_wd      = '0;
      if (!clr) begin
         if ((hold_m || !wb_req) && q.size() > 0) begin
            take_head = 1'b1;
            e_we      = 1'b1;
            e_a3      = q[0].a3;
            e_wd      = q[0].wd;
         end else if (wb_req) begin
            e_we = 1'b1;
            e_a3 = wb_a3;
            e_wd = wb_wd;
         end
      end
      check("grf_we", 64'(grf_we), 64'(e_we));
      if (!clr) begin
         check("grf_a3", 64'(grf_a3), 64'(e_a3));
         check("grf_wd", 64'(grf_wd), 64'(e_wd));
      end
      if (chk_regs) begin
         check("aux_ready", 64'(aux_ready), 64'(q.size() < DEPTH));
         check("busy_mask", 64'(busy_mask), 64'(model_busy()));
         check("aux_count", 64'(aux_count), 64'(q.size()));
         check("wb_hold",   64'(wb_hold),   64'(hold_m));
         if (wb_req && !clr) check("order", 64'(busy_mask[wb_a3]), 64'd0);
      end
      if (clr) begin
         q.delete();
         blocked_cycles = 0;
         hold_m         = 1'b0;
         chk_regs       = 1'b1;
      end else begin
         nonempty_m = (q.size() > 0);
         full_m     = (q.size() >= DEPTH);
         new_hold   = 1'b0;
         if (take_head) begin
            void'(q.pop_front());
            blocked_cycles = 0;
         end else if (wb_req && nonempty_m && GUARD) begin
            blocked_cycles++;
            if (blocked_cycles == STARVE_LIMIT) new_hold = 1'b1;
         end
         if (aux_valid && !full_m && aux_a3 != 5'd0) begin
            r.a3 = aux_a3;
            r.wd = aux_wd;
            q.push_back(r);
         end
         hold_m = new_hold;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          hold_at;
      logic [31:0] mb;
      logic        we;
      logic [4:0]  a3;
      int          pct;

      // 1: reset, then an idle cycle
      drive(1, 0, 0, 0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      check("t1_ready", 64'(aux_ready), 64'd1);
      check("t1_count", 64'(aux_count), 64'd0);
      check("t1_busy",  64'(busy_mask), 64'd0);
      check("t1_we",    64'(grf_we),    64'd0);
      step();

      // 2: WB passes straight through in the same cycle
      drive(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
      #2;
      check("t2_we", 64'(grf_we), 64'd1);
      check("t2_a3", 64'(grf_a3), 64'd5);
      check("t2_wd", 64'(grf_wd), 64'hDEADBEEF);
      step();
      check("t2_count", 64'(aux_count), 64'd0);

      // 3: single aux write lands the next cycle, busy bit for that cycle only
      drive(0, 0, 0, 0, 1, 5'd8, 32'h00001234);
      step();
      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      check("t3_we",   64'(grf_we),       64'd1);
      check("t3_a3",   64'(grf_a3),       64'd8);
      check("t3_wd",   64'(grf_wd),       64'h00001234);
      check("t3_busy", 64'(busy_mask[8]), 64'd1);
      step();
      check("t3_busy_clr", 64'(busy_mask[8]), 64'd0);
      step();

      // 4: fill the queue behind continuous WB, then drain in order
      for (int i = 1; i <= 4; i++) begin
         drive(0, 1, 5'd20, $urandom, 1, 5'(i), 32'(i * 32'h111));
         step();
      end
      check("t4_ready_full", 64'(aux_ready), 64'd0);
      check("t4_count_full", 64'(aux_count), 64'd4);
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 5'd20, $urandom, 1, 5'd5, 32'h5555);
         step();
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         #2;
         check("t4_drain_a3", 64'(grf_a3), 64'(i));
         step();
      end
      check("t4_ready_after", 64'(aux_ready), 64'd1);

      // 5: WB to $0 yields the port to the head; aux to $0 is discarded
      drive(0, 1, 5'd20, 32'h1, 1, 5'd9, 32'h99);
      step();
      drive(0, 1, 5'd0, 32'hFFFF, 1, 5'd0, 32'h77);
      #2;
      check("t5_we", 64'(grf_we), 64'd1);
      check("t5_a3", 64'(grf_a3), 64'd9);
      step();
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
      check("t5_count", 64'(aux_count), 64'd0);

      // 6: one aux entry starved by continuous WB
      drive(0, 1, 5'd20, $urandom, 1, 5'd12, 32'hC0DE);
      step();
      hold_at = 0;
      for (int k = 1; k <= 20; k++) begin
         drive(0, 1, 5'd20, $urandom, 0, 0, 0);
         #2;
         if (wb_hold && hold_at == 0) begin
            hold_at = k;
            check("t6_head_a3", 64'(grf_a3), 64'd12);
         end
         step();
      end
      check("t6_hold_at", 64'(hold_at), GUARD ? 64'(STARVE_LIMIT + 1) : 64'd0);
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) step();

      // 7: reset in the middle of a drain discards everything queued
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 5'd21, $urandom, 1, 5'(13 + i), 32'hA000 + 32'(i));
         step();
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
      drive(1, 0, 0, 0, 0, 0, 0);
      #2;
      check("t7_we_clr", 64'(grf_we), 64'd0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         #2;
         check("t7_count", 64'(aux_count), 64'd0);
         check("t7_busy",  64'(busy_mask), 64'd0);
         check("t7_we",    64'(grf_we),    64'd0);
         step();
      end

      // Random traffic: phases of light, heavy and mixed WB load; WB stalls on busy regs
      for (int n = 0; n < 1500; n++) begin
         case ((n / 100) % 3)
            0:       pct = 30;
            1:       pct = 95;
            default: pct = 60;
         endcase
         mb = model_busy();
         we = ($urandom_range(0, 99) < pct);
         a3 = 5'($urandom_range(0, 31));
         if (mb[a3]) we = 1'b0;
         drive(($urandom_range(0, 199) == 0), we, a3, $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
